muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer for the multi-cycle MIPS core (MULTU/DIVU, HI/LO results).
- Has no adder of its own. Each iteration's add or subtract is issued to an external 32-bit ALU instance through alu_srca/alu_srcb/alu_ctrl, and the sum comes back on alu_result.
- Only the carry/borrow and compare logic are local.
- Runs alongside the main FSM, which stalls on busy and reads hi/lo after done.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU.
- ALU_ADD, 3'b000, ALU control code for add.
- ALU_SUB, 3'b001, ALU control code for subtract.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- op  input  1  0 = unsigned multiply, 1 = unsigned divide
- a  input  WIDTH  multiplicand / dividend, sampled with start
- b  input  WIDTH  multiplier / divisor, sampled with start
- alu_srca  output  WIDTH  ALU operand A
- alu_srcb  output  WIDTH  ALU operand B
- alu_ctrl  output  3  ALU operation code
- alu_result  input  WIDTH  ALU output, combinational from alu_srca/alu_srcb/alu_ctrl
- busy  output  1  high in RUN
- done  output  1  high for exactly one cycle in DONE
- hi  output  WIDTH  product[63:32] or remainder
- lo  output  WIDTH  product[31:0] or quotient

Behaviour:
- States: IDLE, RUN, DONE. Internal registers:
  - P_hi, P_lo: working registers.
  - D: latched b.
  - 6-bit iteration counter cnt.
  - op_r: latched op.
- Reset (asynchronous on reset_n low): state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, cnt = 0, working registers = 0.
- Start acceptance: start=1 in IDLE or DONE at edge E0 latches a, b and op.
  - Normal case: state = RUN, cnt = 0, P_hi = 0, P_lo = a, D = b.
  - start=1 in RUN is ignored; no queuing.
- Divide by zero (op=1, b=0) at E0:
  - Go directly to DONE with lo = 32'hFFFFFFFF, hi = a.
  - done is high the cycle after E0.
- RUN: one iteration per edge, edges E1..E32; cnt increments each iteration.
- Multiply iteration:
  - Combinational outputs: alu_ctrl = ALU_ADD, alu_srca = P_hi, alu_srcb = D.
  - If P_lo[0]=1: s = alu_result, c = (alu_result < P_hi), unsigned compare.
  - Otherwise: s = P_hi, c = 0.
  - Then {P_hi, P_lo} = {c, s, P_lo} >> 1, i.e. a 65-bit right shift keeping the low 64 bits.
- Divide iteration (restoring):
  - r = {P_hi, P_lo[31]} as 33 bits, t = P_hi << 1 | P_lo[31].
  - Combinational outputs: alu_ctrl = ALU_SUB, alu_srca = t[31:0], alu_srcb = D.
  - If r >= {1'b0, D}: P_hi = alu_result (32-bit result is correct mod 2^32 because r < 2·D), quotient bit q = 1.
  - Otherwise: P_hi = t[31:0], q = 0.
  - P_lo = {P_lo[30:0], q}.
- Completion: at E32 (cnt = 31), the final iteration result is written to hi = P_hi_next and lo = P_lo_next; state = DONE.
  - done is high for the cycle after E32, i.e. 32 cycles after the start edge.
- DONE lasts one cycle. Next state is RUN if start=1 (back-to-back operation), otherwise IDLE.
- hi/lo update only on completion (including the divide-by-zero case); they hold their value in all other cycles and across a new RUN.
- ALU outputs outside RUN: alu_ctrl = ALU_ADD, alu_srca = 0, alu_srcb = 0.
- busy = (state == RUN); done = (state == DONE); both are decoded from registered state.
- Reset mid-RUN aborts immediately: hi/lo = 0, no done pulse.
- Width rule: all ALU traffic is 32-bit. The carry (multiply) and 33rd remainder bit (divide) are derived locally and never requested from the ALU.

Test Plan:
- Multiply: op=0, a=7, b=6, start one cycle -> busy for 32 cycles; done pulses once; hi=0, lo=42. alu_ctrl=000 throughout RUN.
- Multiply, all ones: a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Exercises carry on every iteration.
- Divide: op=1, a=100, b=7 -> lo=14, hi=2. Also a=32'hFFFFFFFF, b=32'h80000001 -> lo=1, hi=32'h7FFFFFFE; this exercises the 33-bit remainder path. alu_ctrl=001 in RUN.
- Divide by zero: a=32'h12345678, b=0 -> done one cycle after start; lo=32'hFFFFFFFF, hi=32'h12345678; busy never asserted.
- Start handling: start held high for 40 cycles with op=0, a=3, b=5 -> first result hi=0, lo=15 at cycle 32; the DONE-state start launches a second operation with no IDLE gap. Pulses during RUN change nothing.
- Reset mid-operation: reset_n low at iteration 10 of a multiply -> immediately busy=0, done=0, hi=lo=0; after release, state is IDLE and a new start completes correctly.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer (MULTU/DIVU) that borrows an
// external ALU for its per-iteration add/subtract; results land in hi/lo.
module muldiv_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [5:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] phi_reg, phi_next;
  logic [WIDTH-1:0] plo_reg, plo_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             op_reg, op_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;

  logic [WIDTH-1:0] t_val, s_val;
  logic [WIDTH:0]   r_val;
  logic             c_val, q_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      phi_reg   <= '0;
      plo_reg   <= '0;
      d_reg     <= '0;
      op_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      phi_reg   <= phi_next;
      plo_reg   <= plo_next;
      d_reg     <= d_next;
      op_reg    <= op_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phi_next   = phi_reg;
    plo_next   = plo_reg;
    d_next     = d_reg;
    op_next    = op_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    alu_ctrl   = ALU_ADD;
    alu_srca   = '0;
    alu_srcb   = '0;
    // Restoring-divide shift: the 33rd remainder bit comes from phi_reg[MSB].
    t_val      = {phi_reg[WIDTH-2:0], plo_reg[WIDTH-1]};
    r_val      = {phi_reg, plo_reg[WIDTH-1]};
    s_val      = phi_reg;
    c_val      = 1'b0;
    q_val      = 1'b0;

    case (state_reg)
      RUN: begin
        alu_srcb = d_reg;
        if (!op_reg) begin
          alu_ctrl = ALU_ADD;
          alu_srca = phi_reg;
          if (plo_reg[0]) begin
            s_val = alu_result;
            c_val = (alu_result < phi_reg);
          end
          phi_next = {c_val, s_val[WIDTH-1:1]};
          plo_next = {s_val[0], plo_reg[WIDTH-1:1]};
        end else begin
          alu_ctrl = ALU_SUB;
          alu_srca = t_val;
          if (r_val >= {1'b0, d_reg}) begin
            phi_next = alu_result;
            q_val    = 1'b1;
          end else begin
            phi_next = t_val;
          end
          plo_next = {plo_reg[WIDTH-2:0], q_val};
        end
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'(WIDTH - 1)) begin
          hi_next    = phi_next;
          lo_next    = plo_next;
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
        if (start) begin
          op_next = op;
          if (op && (b == '0)) begin
            hi_next    = a;
            lo_next    = '1;
            state_next = DONE;
          end else begin
            cnt_next   = '0;
            phi_next   = '0;
            plo_next   = a;
            d_next     = b;
            state_next = RUN;
          end
        end
      end
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus queues expected hi/lo, a monitor
// pops and compares on every done pulse; side checks are funnelled to it too.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]  alu_ctrl;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference ALU standing in for the core's shared 32-bit ALU.
  assign alu_result = (alu_ctrl == 3'b001) ? (alu_srca - alu_srcb) : (alu_srca + alu_srcb);

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  chk_t chk_q[$];
  int   passed = 0;
  int   total  = 0;

  always @(negedge clk) begin
    if (done) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_done: got hi=%h lo=%h required no done", hi, lo);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if ({hi, lo} === e.exp) begin
          passed++;
          $display("ok   %s: hi=%h lo=%h", e.name, hi, lo);
        end else
          $display("FAIL %s: got hi=%h lo=%h required hi=%h lo=%h",
                   e.name, hi, lo, e.exp[63:32], e.exp[31:0]);
      end
    end
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      total++;
      if (c.act === c.exp) begin
        passed++;
        $display("ok   %s: %0h", c.name, c.act);
      end else
        $display("FAIL %s: got %0h required %0h", c.name, c.act, c.exp);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_q.push_back('{name: name, act: act, exp: exp});
  endtask

  // One operation: start for one edge (E0), then count edges until done.
  task automatic run_op(input string name, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi,
                        input logic [31:0] elo, input int lat);
    int n, nbusy, badctrl;
    logic [2:0] ectrl;
    ectrl = o ? 3'b001 : 3'b000;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back('{name: name, exp: {ehi, elo}});
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; nbusy = 0; badctrl = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) begin
        nbusy++;
        if (alu_ctrl !== ectrl) badctrl++;
      end
      if (n > 100) begin
        chk({name, "_timeout"}, 64'(n), 64'(lat));
        break;
      end
      @(posedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_busy_cycles"}, 64'(nbusy), (lat == 0) ? 64'd0 : 64'd32);
    chk({name, "_alu_ctrl_bad"}, 64'(badctrl), 64'd0);
  endtask

  initial begin
    int first, second;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("idle_alu_src", {alu_srca, alu_srcb}, 64'd0);
    chk("idle_alu_ctrl", 64'(alu_ctrl), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 32);
    run_op("mul_ones", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 32);
    run_op("div_33bit", 1'b1, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1, 32);
    run_op("div_zero", 1'b1, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 0);

    // start held high: second op launches straight from DONE, no IDLE gap.
    @(posedge clk); #1;
    op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    sb_q.push_back('{name: "b2b_first", exp: {32'd0, 32'd15}});
    sb_q.push_back('{name: "b2b_second", exp: {32'd0, 32'd15}});
    first = -1; second = -1;
    for (int i = 0; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == 40) start = 1'b0;
      @(negedge clk);
      if (done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("b2b_first_edge", 64'(first), 64'd32);
    chk("b2b_second_edge", 64'(second), 64'd65);

    // Reset mid-multiply: hi/lo currently hold 15, must clear with no done.
    @(posedge clk); #1;
    op = 1'b0; a = 32'd9; b = 32'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {62'd0, busy, done}, 64'd0);
    run_op("mul_13x17", 1'b0, 32'd13, 32'd17, 32'd0, 32'd221, 32);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
